fifo_burst_reader: RTL and testbench

Read-side consumer for the team's asynchronous FIFO, living entirely in the read clock domain. It pops words from the FIFO's show-ahead read port and repackages them as framed bursts of up to MyBurstLen words on a valid/ready output stream. Partial bursts are closed by an idle timeout. It gives downstream logic explicit first/last framing without knowledge of FIFO fill state.

---
 rtl/fifo_burst_reader_pkg.sv | 21 ++
 rtl/fifo_burst_reader_timer.sv | 30 +++
 rtl/fifo_burst_reader.sv | 160 ++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// fifo_burst_reader_pkg: shared state encoding and counter width helpers
// for the FIFO burst reader.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        LASTQ = 2'd2
    } burstState_t;

    // Bits needed for a beat counter that reaches burstLen without wrapping
    function automatic int unsigned beatWidth(input int unsigned burstLen);
        return (burstLen < 1) ? 1 : $clog2(burstLen + 1);
    endfunction

    // Bits needed for an idle timer that saturates at timeout
    function automatic int unsigned timerWidth(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fifo_burst_reader_timer.sv
// burst_idle_timer: saturating idle counter with synchronous clear,
// increment enable and a terminal flag. Only built when
// MY_BURST_TIMEOUT_EN is defined.
module burst_idle_timer #(
    parameter int unsigned MyWidth = 5,
    parameter int unsigned MyLimit = 16
) (
    input  logic myClk,
    input  logic myRst,
    input  logic myClr,
    input  logic myInc,
    output logic atLimit_c
);

    logic [MyWidth-1:0] count;

    // Count idle cycles, hold at the limit, restart on clear
    always_ff @(posedge myClk or posedge myRst) begin
        if (myRst) begin
            count <= '0;
        end else if (myClr) begin
            count <= '0;
        end else if (myInc && (count != MyWidth'(MyLimit))) begin
            count <= count + MyWidth'(1);
        end
    end

    assign atLimit_c = (count == MyWidth'(MyLimit));

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops the async FIFO's show-ahead read port and
// re-emits the words as first/last framed bursts of up to MyBurstLen
// words on a valid/ready stream.
// Optional feature macro: MY_BURST_TIMEOUT_EN closes a partial burst
// after MyTimeout idle cycles; without it a partial burst waits for data.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned MyDepthSize = 8,
    parameter int unsigned MyBurstLen  = 4,
    parameter int unsigned MyTimeout   = 16
) (
    input  logic                   myRclk,
    input  logic                   myRrst,
    output logic                   myRreq,
    input  logic                   myRempty,
    input  logic [MyDepthSize-1:0] myRdata,
    output logic                   myOutValid,
    input  logic                   myOutReady,
    output logic [MyDepthSize-1:0] myOutData,
    output logic                   myOutFirst,
    output logic                   myOutLast,
    output logic                   myBusy
);

    localparam int unsigned BeatW = beatWidth(MyBurstLen);
    localparam logic [BeatW-1:0] BeatOne  = BeatW'(1);
    localparam logic [BeatW-1:0] BeatFull = BeatW'(MyBurstLen);
    localparam burstState_t RestartState = (MyBurstLen == 1) ? LASTQ : HOLD;

    // Reject degenerate configurations at elaboration
    if (MyBurstLen < 1 || MyTimeout < 1) begin : gBadParam
        $error("fifo_burst_reader: MyBurstLen and MyTimeout must be >= 1");
    end

    burstState_t            state;
    burstState_t            nextState;
    logic [MyDepthSize-1:0] holdData;
    logic                   holdFirst;
    logic [BeatW-1:0]       beat;
    logic                   outFree;
    logic                   popNow;
    logic                   loadOut;
    logic                   loadLast;
    logic                   timerHit;

    assign outFree = !myOutValid || myOutReady;
    assign myRreq  = popNow;

`ifdef MY_BURST_TIMEOUT_EN
    localparam int unsigned TimerW = timerWidth(MyTimeout);

    logic timerClr;

    // Timer only runs in HOLD between pops
    assign timerClr = popNow || (state != HOLD);

    burst_idle_timer #(
        .MyWidth (TimerW),
        .MyLimit (MyTimeout)
    ) uIdleTimer (
        .myClk     (myRclk),
        .myRst     (myRrst),
        .myClr     (timerClr),
        .myInc     (!timerClr),
        .atLimit_c (timerHit)
    );
`else
    assign timerHit = 1'b0;
`endif

    // State register
    always_ff @(posedge myRclk or posedge myRrst) begin
        if (myRrst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state, pop request and output-load decode
    always_comb begin
        nextState = state;
        popNow    = 1'b0;
        loadOut   = 1'b0;
        loadLast  = 1'b0;
        unique case (state)
            IDLE: begin
                popNow = !myRempty && !myRrst;
                if (popNow) begin
                    nextState = RestartState;
                end
            end
            HOLD: begin
                popNow = !myRempty && outFree && !myRrst;
                if (popNow) begin
                    loadOut = 1'b1;
                    if ((beat + BeatOne) == BeatFull) begin
                        nextState = LASTQ;
                    end
                end else if (timerHit && outFree) begin
                    loadOut   = 1'b1;
                    loadLast  = 1'b1;
                    nextState = IDLE;
                end
            end
            LASTQ: begin
                popNow = !myRempty && outFree && !myRrst;
                if (outFree) begin
                    loadOut   = 1'b1;
                    loadLast  = 1'b1;
                    nextState = popNow ? RestartState : IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Hold register and beat counter: capture the FIFO head on every pop
    always_ff @(posedge myRclk or posedge myRrst) begin
        if (myRrst) begin
            holdData  <= '0;
            holdFirst <= 1'b0;
            beat      <= '0;
        end else if (popNow) begin
            holdData  <= myRdata;
            holdFirst <= (state != HOLD);
            beat      <= (state == HOLD) ? (beat + BeatOne) : BeatOne;
        end
    end

    // Output register: load from hold, drop valid once accepted
    always_ff @(posedge myRclk or posedge myRrst) begin
        if (myRrst) begin
            myOutValid <= 1'b0;
            myOutData  <= '0;
            myOutFirst <= 1'b0;
            myOutLast  <= 1'b0;
        end else if (loadOut) begin
            myOutValid <= 1'b1;
            myOutData  <= holdData;
            myOutFirst <= holdFirst;
            myOutLast  <= loadLast;
        end else if (myOutReady) begin
            myOutValid <= 1'b0;
        end
    end

    // Busy flag tracks the registered state
    always_ff @(posedge myRclk or posedge myRrst) begin
        if (myRrst) begin
            myBusy <= 1'b0;
        end else begin
            myBusy <= (nextState != IDLE);
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: randomized and directed scoreboard bench for
// fifo_burst_reader. A queue models the FIFO; every popped word is pushed
// to an expected queue and a negedge monitor checks data and framing.
module tb_fifo_burst_reader;

    localparam int unsigned W = 8;
    localparam int unsigned L = 4;
    localparam int unsigned T = 16;
`ifdef MY_BURST_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] data;
        int           t;
    } exp_t;

    logic         myRclk = 1'b0;
    logic         myRrst = 1'b1;
    logic         myRreq;
    logic         myRempty = 1'b1;
    logic [W-1:0] myRdata = '0;
    logic         myOutValid;
    logic         myOutReady = 1'b1;
    logic [W-1:0] myOutData;
    logic         myOutFirst;
    logic         myOutLast;
    logic         myBusy;

    fifo_burst_reader #(
        .MyDepthSize (W),
        .MyBurstLen  (L),
        .MyTimeout   (T)
    ) dut (
        .myRclk     (myRclk),
        .myRrst     (myRrst),
        .myRreq     (myRreq),
        .myRempty   (myRempty),
        .myRdata    (myRdata),
        .myOutValid (myOutValid),
        .myOutReady (myOutReady),
        .myOutData  (myOutData),
        .myOutFirst (myOutFirst),
        .myOutLast  (myOutLast),
        .myBusy     (myBusy)
    );

    always #5 myRclk = ~myRclk;

    int           nTests = 0;
    int           nFail  = 0;
    int           cyc    = 0;
    int           pos    = 0;
    int           popsSinceRst = 0;
    bit           popPending = 1'b0;
    logic [W-1:0] fifoQ[$];
    logic [W-1:0] pushQ[$];
    exp_t         expQ[$];
    int           xferAt[256];
    int           popAt[256];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        nTests++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // One clock: retire the pop seen last cycle, apply pushes, refresh FIFO outputs
    task automatic step();
        @(posedge myRclk);
        cyc++;
        #1;
        if (popPending && fifoQ.size() > 0) begin
            expQ.push_back('{data: fifoQ[0], t: cyc});
            popAt[fifoQ[0]] = cyc;
            void'(fifoQ.pop_front());
            popsSinceRst++;
        end
        while (pushQ.size() > 0) fifoQ.push_back(pushQ.pop_front());
        myRempty = (fifoQ.size() == 0);
        myRdata  = (fifoQ.size() == 0) ? '0 : fifoQ[0];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: reset values, pop legality, and scoreboard compare on each transfer
    exp_t e;
    bit   timedOut;
    bit   eLast;
    always @(negedge myRclk) begin
        popPending = myRreq;
        if (myRrst) begin
            pos = 0;
            chk("rst_valid", myOutValid, 0);
            chk("rst_data",  myOutData,  0);
            chk("rst_first", myOutFirst, 0);
            chk("rst_last",  myOutLast,  0);
            chk("rst_busy",  myBusy,     0);
            chk("rst_rreq",  myRreq,     0);
        end else begin
            chk("pop_when_empty", myRreq && myRempty, 0);
            if (myOutValid && myOutReady) begin
                if (expQ.size() == 0) begin
                    nTests++;
                    nFail++;
                    $display("FAIL out_unexpected: got %0h expected no word (cycle %0d)", myOutData, cyc);
                end else begin
                    e = expQ.pop_front();
                    timedOut = TmoEn && ((expQ.size() == 0) || (expQ[0].t > e.t + int'(T) + 1));
                    eLast = (pos == int'(L) - 1) || timedOut;
                    chk("out_data",  myOutData,  e.data);
                    chk("out_first", myOutFirst, (pos == 0));
                    chk("out_last",  myOutLast,  eLast);
                    if (timedOut && pos != int'(L) - 1)
                        chk("tmo_edge", cyc, e.t + int'(T) + 1);
                    xferAt[e.data] = cyc;
                    pos = eLast ? 0 : pos + 1;
                end
            end
        end
    end

    int dens;
    int tR1;
    initial begin
        for (int i = 0; i < 256; i++) begin
            xferAt[i] = 0;
            popAt[i]  = 0;
        end
        idle(3);
        myRrst = 1'b0;
        idle(2);

        // Full bursts back to back: 0x10..0x17 over 8 consecutive cycles
        for (int i = 0; i < 8; i++) pushQ.push_back(W'(8'h10 + i));
        idle(14);
        chk("burst_span", xferAt[8'h17] - xferAt[8'h10], 7);

        // Backpressure mid-burst
        for (int i = 0; i < 8; i++) pushQ.push_back(W'(8'h30 + i));
        idle(4);
        myOutReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            chk("bp_valid", myOutValid, 1);
            chk("bp_data",  myOutData,  (expQ.size() > 0) ? expQ[0].data : 8'hxx);
            chk("bp_rreq",  myRreq,     0);
        end
        myOutReady = 1'b1;
        idle(14);
        chk("bp_drained", expQ.size(), 0);

        // Two words then an empty FIFO
        pushQ.push_back(8'hA1);
        pushQ.push_back(8'hA2);
        idle(25);
        if (TmoEn) begin
            chk("tmo_flushed", expQ.size(), 0);
            chk("tmo_latency", xferAt[8'hA2] - popAt[8'hA2], T + 1);
        end else begin
            chk("notmo_pending", expQ.size(), 1);
            chk("notmo_word", (expQ.size() > 0) ? expQ[0].data : 8'hxx, 8'hA2);
        end
        pushQ.push_back(8'hA3);
        idle(25);

        // Race: second word lands exactly when the timer saturates
        pushQ.push_back(8'hB1);
        idle(2);
        tR1 = popAt[8'hB1];
        while (cyc < tR1 + int'(T) - 1) step();
        pushQ.push_back(8'hB2);
        idle(2);
        chk("race_pop", popAt[8'hB2] - tR1, T + 1);
        pushQ.push_back(8'hB3);
        pushQ.push_back(8'hB4);
        idle(25);

        // Reset mid-burst discards held data; next burst starts fresh
        pushQ.push_back(8'h61);
        pushQ.push_back(8'h62);
        idle(3);
        myRrst = 1'b1;
        expQ.delete();
        popsSinceRst = 0;
        step();
        myRrst = 1'b0;
        for (int i = 0; i < 4; i++) pushQ.push_back(W'(8'h55 + i));
        idle(12);
        chk("rst_restart_seen", (xferAt[8'h55] > 0), 1);

        // Randomized traffic with varying FIFO density
        dens = 50;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(0, 3))
                    0: dens = 3;
                    1: dens = 20;
                    2: dens = 60;
                    default: dens = 95;
                endcase
            end
            if ($urandom_range(0, 99) < dens) pushQ.push_back(W'($urandom));
            myOutReady = TmoEn ? 1'b1 : ($urandom_range(0, 99) < 70);
            step();
        end

        // Drain and check what must still be held
        myOutReady = 1'b1;
        idle(60);
        if (TmoEn) begin
            chk("end_pending", expQ.size(), 0);
            chk("end_busy", myBusy, 0);
        end else begin
            chk("end_pending", expQ.size(), (popsSinceRst % int'(L) != 0) ? 1 : 0);
            chk("end_busy", myBusy, (popsSinceRst % int'(L) != 0) ? 1 : 0);
        end
        chk("end_fifo_empty", fifoQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
